// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard controller: stage indices, FSM state
// encoding and default parameter values.
// Optional feature macro: HAZARD_EXC_EN (adds the EXC_FLUSH state).
package hazard_pkg;

    localparam int STG_F = 0;
    localparam int STG_D = 1;
    localparam int STG_E = 2;
    localparam int STG_M = 3;
    localparam int STG_W = 4;

    localparam int DEF_ISSUE_WIDTH = 2;
    localparam int DEF_REG_AW      = 5;
    localparam int DEF_DIV_CYCLES  = 34;

`ifdef HAZARD_EXC_EN
    typedef enum logic [1:0] {
        RUN       = 2'd0,
        DIV_WAIT  = 2'd1,
        EXC_FLUSH = 2'd2
    } hz_state_t;
`else
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DIV_WAIT = 2'd1
    } hz_state_t;
`endif

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle. The pipeline side uses the
// master modport, the controller uses the slave modport.
// Optional feature macro: HAZARD_EXC_EN (adds e_exc).
interface hazard_ctrl_if #(
    parameter int ISSUE_WIDTH = hazard_pkg::DEF_ISSUE_WIDTH,
    parameter int REG_AW      = hazard_pkg::DEF_REG_AW
);
    logic [ISSUE_WIDTH-1:0]        d_valid;
    logic [ISSUE_WIDTH*REG_AW-1:0] d_rs;
    logic [ISSUE_WIDTH*REG_AW-1:0] d_rt;
    logic [ISSUE_WIDTH-1:0]        e_memtoreg;
    logic [ISSUE_WIDTH-1:0]        m_memtoreg;
    logic [ISSUE_WIDTH*REG_AW-1:0] e_waddr;
    logic [ISSUE_WIDTH*REG_AW-1:0] m_waddr;
    logic                          e_branch_taken;
    logic                          e_div_start;
`ifdef HAZARD_EXC_EN
    logic                          e_exc;
`endif
    logic [4:0]                    stage_ena;
    logic [4:0]                    stage_flush;
    logic                          div_busy;
    logic [31:0]                   stall_cycles;

    modport master (
`ifdef HAZARD_EXC_EN
        output e_exc,
`endif
        output d_valid, d_rs, d_rt, e_memtoreg, m_memtoreg,
        output e_waddr, m_waddr, e_branch_taken, e_div_start,
        input  stage_ena, stage_flush, div_busy, stall_cycles
    );

    modport slave (
`ifdef HAZARD_EXC_EN
        input  e_exc,
`endif
        input  d_valid, d_rs, d_rt, e_memtoreg, m_memtoreg,
        input  e_waddr, m_waddr, e_branch_taken, e_div_start,
        output stage_ena, stage_flush, div_busy, stall_cycles
    );

endinterface

// File: rtl/hazard_lduse_cmp.sv
// Load-use comparator: flags a stall when any valid decode lane reads a
// non-zero register that a load in E or M (any lane) is about to write.
module hazard_lduse_cmp #(
    parameter int ISSUE_WIDTH = hazard_pkg::DEF_ISSUE_WIDTH,
    parameter int REG_AW      = hazard_pkg::DEF_REG_AW
) (
    input  logic [ISSUE_WIDTH-1:0]        d_valid,
    input  logic [ISSUE_WIDTH*REG_AW-1:0] d_rs,
    input  logic [ISSUE_WIDTH*REG_AW-1:0] d_rt,
    input  logic [ISSUE_WIDTH-1:0]        e_memtoreg,
    input  logic [ISSUE_WIDTH-1:0]        m_memtoreg,
    input  logic [ISSUE_WIDTH*REG_AW-1:0] e_waddr,
    input  logic [ISSUE_WIDTH*REG_AW-1:0] m_waddr,
    output logic                          ld_stall
);

    // Compare every decode source against every in-flight load destination
    always_comb begin
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] ew;
        logic [REG_AW-1:0] mw;
        ld_stall = 1'b0;
        for (int d = 0; d < ISSUE_WIDTH; d++) begin
            rs = d_rs[d*REG_AW +: REG_AW];
            rt = d_rt[d*REG_AW +: REG_AW];
            for (int p = 0; p < ISSUE_WIDTH; p++) begin
                ew = e_waddr[p*REG_AW +: REG_AW];
                mw = m_waddr[p*REG_AW +: REG_AW];
                if (d_valid[d]) begin
                    if (rs != '0 && ((e_memtoreg[p] && rs == ew) ||
                                     (m_memtoreg[p] && rs == mw)))
                        ld_stall = 1'b1;
                    if (rt != '0 && ((e_memtoreg[p] && rt == ew) ||
                                     (m_memtoreg[p] && rt == mw)))
                        ld_stall = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, multi-cycle divide freeze,
// branch flush of D/E, and (optionally) a one-cycle exception flush.
// Optional feature macro: HAZARD_EXC_EN (adds e_exc and EXC_FLUSH).
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int ISSUE_WIDTH = DEF_ISSUE_WIDTH,
    parameter int REG_AW      = DEF_REG_AW,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        resetn,
    hazard_ctrl_if.slave bus
);

    localparam logic [7:0] DIV_LOAD = 8'(DIV_CYCLES - 1);

    hz_state_t   state_q, state_d;
    logic [7:0]  div_cnt_q, div_cnt_d;
    logic [31:0] stall_q;
    logic [4:0]  ena;
    logic [4:0]  flush;
    logic        ld_stall;

    hazard_lduse_cmp #(
        .ISSUE_WIDTH(ISSUE_WIDTH),
        .REG_AW     (REG_AW)
    ) u_lduse (
        .d_valid   (bus.d_valid),
        .d_rs      (bus.d_rs),
        .d_rt      (bus.d_rt),
        .e_memtoreg(bus.e_memtoreg),
        .m_memtoreg(bus.m_memtoreg),
        .e_waddr   (bus.e_waddr),
        .m_waddr   (bus.m_waddr),
        .ld_stall  (ld_stall)
    );

    // Next state, divide counter update and stage enable/flush decode
    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        ena       = 5'b11111;
        flush     = 5'b00000;
        case (state_q)
            RUN: begin
                ena[STG_F] = ~ld_stall;
                ena[STG_D] = ~ld_stall;
`ifdef HAZARD_EXC_EN
                if (bus.e_exc) begin
                    state_d   = EXC_FLUSH;
                    div_cnt_d = 8'd0;
                end else
`endif
                begin
                    flush[STG_D] = bus.e_branch_taken;
                    flush[STG_E] = bus.e_branch_taken;
                    if (bus.e_div_start) begin
                        ena       = 5'b00000;
                        state_d   = DIV_WAIT;
                        div_cnt_d = DIV_LOAD;
                    end
                end
            end
            DIV_WAIT: begin
                ena = 5'b00000;
`ifdef HAZARD_EXC_EN
                if (bus.e_exc) begin
                    state_d   = EXC_FLUSH;
                    div_cnt_d = 8'd0;
                end else
`endif
                begin
                    div_cnt_d = div_cnt_q - 8'd1;
                    if (div_cnt_q <= 8'd1) begin
                        state_d   = RUN;
                        div_cnt_d = 8'd0;
                    end
                end
            end
`ifdef HAZARD_EXC_EN
            EXC_FLUSH: begin
                flush   = 5'b11111;
                state_d = RUN;
            end
`endif
            default: begin
                state_d   = RUN;
                div_cnt_d = 8'd0;
            end
        endcase
    end

    // State, divide counter and stall statistics registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= RUN;
            div_cnt_q <= 8'd0;
            stall_q   <= 32'd0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            if (!ena[STG_D])
                stall_q <= stall_q + 32'd1;
        end
    end

    assign bus.stage_ena    = resetn ? ena   : 5'b11111;
    assign bus.stage_flush  = resetn ? flush : 5'b00000;
    assign bus.div_busy     = (div_cnt_q != 8'd0);
    assign bus.stall_cycles = stall_q;

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter ISSUE_WIDTH, default 2, number of issue lanes (lane 0 = master).
REQ-002 Parameter REG_AW, default 5, register address width.
REQ-003 Parameter DIV_CYCLES, default 34, divider occupancy in cycles, range 2..255.
REQ-004 clk  in  1  pipeline clock; only clock; all state on rising edge.
REQ-005 resetn  in  1  asynchronous, active-low reset.
REQ-006 d_valid  in  ISSUE_WIDTH  decode-lane valid.
REQ-007 d_rs, d_rt  in  ISSUE_WIDTH*REG_AW each  decode source registers, lane i at bits [i*REG_AW +: REG_AW].
REQ-008 e_memtoreg, m_memtoreg  in  ISSUE_WIDTH each  per-lane load in E and M.
REQ-009 e_waddr, m_waddr  in  ISSUE_WIDTH*REG_AW each  per-lane destination in E and M.
REQ-010 e_branch_taken  in  1  branch resolved taken in E.
REQ-011 e_div_start  in  1  divide issued in E this cycle.
REQ-012 e_exc  in  1  exception raised in E (HAZARD_EXC_EN only).
REQ-013 stage_ena  out  5  enables, index 0..4 = F,D,E,M,W.
REQ-014 stage_flush  out  5  flushes, same indexing.
REQ-015 div_busy  out  1  divider counter non-zero.
REQ-016 stall_cycles  out  32  count of cycles with stage_ena[1] low.

Function
REQ-017 Load-use stall ld_stall = 1 when any valid decode lane's rs or rt, non-zero, equals e_waddr or m_waddr of any lane whose e_/m_memtoreg is 1.
REQ-018 Source register 0 never causes ld_stall.
REQ-019 FSM states RUN, DIV_WAIT, EXC_FLUSH; reset state RUN.
REQ-020 RUN -> DIV_WAIT on e_div_start; counter loads DIV_CYCLES-1.
REQ-021 DIV_WAIT: counter decrements each cycle; at counter==1 next state RUN; div_busy = (counter != 0).
REQ-022 e_div_start ignored in DIV_WAIT and EXC_FLUSH.
REQ-023 In DIV_WAIT all stage_ena = 0 (combinationally, including the e_div_start cycle).
REQ-024 In RUN without divide: stage_ena[0],[1] = ~ld_stall; stage_ena[2..4] = 1.
REQ-025 stage_flush[1],[2] = e_branch_taken, in RUN only; branch in same cycle as ld_stall still flushes D,E; stage_flush[0],[3],[4] = 0 in RUN.
REQ-026 e_exc in RUN or DIV_WAIT -> EXC_FLUSH next cycle, counter cleared, divide abandoned; e_exc has priority over e_div_start and e_branch_taken.
REQ-027 EXC_FLUSH lasts exactly one cycle: stage_flush = 5'b11111, stage_ena = 5'b11111, then RUN.
REQ-028 stall_cycles increments by 1 each cycle stage_ena[1] = 0; wraps 0xFFFFFFFF -> 0.
REQ-029 Total divide stall = DIV_CYCLES cycles from the e_div_start cycle inclusive.

Reset
REQ-030 resetn low: state RUN, counter 0, div_busy 0, stall_cycles 0, stage_flush 0, stage_ena 5'b11111 immediately.
REQ-031 Reset mid-DIV_WAIT or mid-EXC_FLUSH abandons the operation; no residual stall after resetn rises.

Configuration
REQ-032 Macro HAZARD_EXC_EN: defined -> e_exc port and EXC_FLUSH state present per REQ-026/027.
REQ-033 HAZARD_EXC_EN undefined -> no e_exc port, EXC_FLUSH unreachable and removed, all else unchanged.

Structure
REQ-034 Package hazard_pkg holds stage index constants (STG_F..STG_W = 0..4), FSM state enum, and default parameter constants.
REQ-035 One sub-module, hazard_lduse_cmp, computes ld_stall per REQ-017/018 for given ISSUE_WIDTH and REG_AW; FSM, counter, and outputs live in hazard_ctrl.

Verification
REQ-036 Lane1 d_rt=5, e_memtoreg[0]=1, e_waddr lane0=5 -> stage_ena=5'b11100, stage_flush=0, stall_cycles +1.
REQ-037 d_rs=0, m_memtoreg[1]=1, m_waddr lane1=0 -> no stall, stage_ena=5'b11111.
REQ-038 e_div_start pulse, DIV_CYCLES=34 -> stage_ena=0 for exactly 34 cycles; div_busy high 33 cycles; stall_cycles +34.
REQ-039 e_branch_taken with ld_stall -> stage_flush=5'b00110, stage_ena=5'b11100.
REQ-040 HAZARD_EXC_EN: e_exc at divide cycle 10 -> one cycle stage_flush=5'b11111, then RUN, div_busy=0.
REQ-041 resetn low at divide cycle 5 -> outputs to reset values immediately; no stall after release.
